// File: rtl/eq_sched_pkg.sv
// Shared types and constants for the time-multiplexed EQ gain/volume sequencer.
package eq_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCALE = 2'd1,
        VOL_L = 2'd2,
        VOL_R = 2'd3
    } seqState_t;

    localparam int AUD_W = 16;
    localparam int POT_W = 24;
    localparam int VOL_W = 12;
    localparam int ACC_W = 19;

    localparam int GAIN_SHIFT_DFLT = 22;
    localparam int VOL_SHIFT_DFLT  = 12;

    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;

    localparam logic signed [ACC_W-1:0] ACC_HI = ACC_W'(SAT_MAX);
    localparam logic signed [ACC_W-1:0] ACC_LO = ACC_W'(SAT_MIN);

    // Clamp a channel accumulator to the 16-bit audio range.
    function automatic logic signed [AUD_W-1:0] satAcc(input logic signed [ACC_W-1:0] acc);
        logic signed [AUD_W-1:0] res;
        if (acc > ACC_HI) begin
            res = AUD_W'(SAT_MAX);
        end else if (acc < ACC_LO) begin
            res = AUD_W'(SAT_MIN);
        end else begin
            res = acc[AUD_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/eq_scale_sequencer_if.sv
// Sample-side bus of the EQ scale sequencer: band/gain operands in, stereo result out.
interface eq_scale_sequencer_if #(
    parameter int NUM_BANDS = 5
);
    import eq_sched_pkg::*;

    logic                          vld;
    logic [AUD_W*NUM_BANDS-1:0]    band_lft;
    logic [AUD_W*NUM_BANDS-1:0]    band_rght;
    logic [POT_W*NUM_BANDS-1:0]    pot;
    logic [VOL_W-1:0]              vol_pot;
    logic                          clr_ovr;
    logic signed [AUD_W-1:0]       aud_out_lft;
    logic signed [AUD_W-1:0]       aud_out_rght;
    logic                          out_vld;
    logic                          busy;
    logic                          overrun;

    modport master (
        output vld, band_lft, band_rght, pot, vol_pot, clr_ovr,
        input  aud_out_lft, aud_out_rght, out_vld, busy, overrun
    );

    modport slave (
        input  vld, band_lft, band_rght, pot, vol_pot, clr_ovr,
        output aud_out_lft, aud_out_rght, out_vld, busy, overrun
    );

endinterface

// File: rtl/eq_sat_shift.sv
// Arithmetic right shift with saturation to 16 bits; EQ_ROUND_EN adds half an LSB first.
module eq_sat_shift
    import eq_sched_pkg::*;
#(
    parameter int IN_W  = 41,
    parameter int SHIFT = 22
) (
    input  logic signed [IN_W-1:0]  prod,
    output logic signed [AUD_W-1:0] result
);

    // One guard bit so the rounding offset can never wrap the product.
    localparam int EXT_W = IN_W + 1;
    localparam logic signed [EXT_W-1:0] HI = EXT_W'(SAT_MAX);
    localparam logic signed [EXT_W-1:0] LO = EXT_W'(SAT_MIN);
`ifdef EQ_ROUND_EN
    localparam logic signed [EXT_W-1:0] HALF = EXT_W'(1) <<< (SHIFT - 1);
`endif

    logic signed [EXT_W-1:0] extProd;
    logic signed [EXT_W-1:0] shifted;

    always_comb begin
        extProd = {prod[IN_W-1], prod};
`ifdef EQ_ROUND_EN
        extProd = extProd + HALF;
`endif
        shifted = extProd >>> SHIFT;
        if (shifted > HI) begin
            result = AUD_W'(SAT_MAX);
        end else if (shifted < LO) begin
            result = AUD_W'(SAT_MIN);
        end else begin
            result = shifted[AUD_W-1:0];
        end
    end

endmodule

// File: rtl/eq_scale_sequencer.sv
// Shares one signed multiplier across 2*NUM_BANDS band gains and two volume multiplies.
// Optional EQ_ROUND_EN: round-half-up before both gain and volume shifts.
module eq_scale_sequencer
    import eq_sched_pkg::*;
#(
    parameter int NUM_BANDS  = 5,
    parameter int GAIN_SHIFT = GAIN_SHIFT_DFLT,
    parameter int VOL_SHIFT  = VOL_SHIFT_DFLT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    eq_scale_sequencer_if.slave  bus
);

    localparam int NUM_TERMS = 2 * NUM_BANDS;
    localparam int IDX_W     = $clog2(NUM_TERMS);
    localparam int PROD_W    = AUD_W + POT_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TERMS - 1);
    localparam logic [IDX_W-1:0] LAST_LFT = IDX_W'(NUM_BANDS - 1);

    seqState_t stateReg, stateNext;

    logic [IDX_W-1:0]           idxReg;
    logic [AUD_W*NUM_BANDS-1:0] bandLftReg, bandRghtReg;
    logic [POT_W*NUM_BANDS-1:0] potReg;
    logic [VOL_W-1:0]           volReg;
    logic signed [ACC_W-1:0]    accLftReg, accRghtReg;
    logic signed [AUD_W-1:0]    holdLftReg, outLftReg, outRghtReg;
    logic                       outVldReg, overrunReg;

    logic signed [AUD_W-1:0]    audSel  [NUM_TERMS];
    logic [POT_W-1:0]           gainSel [NUM_TERMS];
    logic signed [AUD_W-1:0]    mulA;
    logic signed [POT_W:0]      mulB;
    logic signed [PROD_W-1:0]   product;
    logic signed [AUD_W-1:0]    termSat, volSat;

    // Term index 0..NUM_BANDS-1 walks the left bands, the rest walk the right bands.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANDS; gi++) begin : g_unpack
            assign audSel[gi]              = bandLftReg[gi*AUD_W +: AUD_W];
            assign audSel[gi + NUM_BANDS]  = bandRghtReg[gi*AUD_W +: AUD_W];
            assign gainSel[gi]             = potReg[gi*POT_W +: POT_W];
            assign gainSel[gi + NUM_BANDS] = potReg[gi*POT_W +: POT_W];
        end
    endgenerate

    always_comb begin
        mulA = audSel[idxReg];
        mulB = {1'b0, gainSel[idxReg]};
        if (stateReg == VOL_L) begin
            mulA = satAcc(accLftReg);
            mulB = {{(POT_W - VOL_W + 1){1'b0}}, volReg};
        end else if (stateReg == VOL_R) begin
            mulA = satAcc(accRghtReg);
            mulB = {{(POT_W - VOL_W + 1){1'b0}}, volReg};
        end
    end

    assign product = PROD_W'(mulA) * PROD_W'(mulB);

    eq_sat_shift #(.IN_W(PROD_W), .SHIFT(GAIN_SHIFT)) u_gainShift (
        .prod   (product),
        .result (termSat)
    );

    eq_sat_shift #(.IN_W(PROD_W), .SHIFT(VOL_SHIFT)) u_volShift (
        .prod   (product),
        .result (volSat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (bus.vld) stateNext = SCALE;
            SCALE:   if (idxReg == LAST_IDX) stateNext = VOL_L;
            VOL_L:   stateNext = VOL_R;
            VOL_R:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idxReg      <= '0;
            bandLftReg  <= '0;
            bandRghtReg <= '0;
            potReg      <= '0;
            volReg      <= '0;
            accLftReg   <= '0;
            accRghtReg  <= '0;
            holdLftReg  <= '0;
            outLftReg   <= '0;
            outRghtReg  <= '0;
            outVldReg   <= 1'b0;
            overrunReg  <= 1'b0;
        end else begin
            outVldReg <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (bus.vld) begin
                        bandLftReg  <= bus.band_lft;
                        bandRghtReg <= bus.band_rght;
                        potReg      <= bus.pot;
                        volReg      <= bus.vol_pot;
                        accLftReg   <= '0;
                        accRghtReg  <= '0;
                        idxReg      <= '0;
                    end
                end
                SCALE: begin
                    if (idxReg <= LAST_LFT) begin
                        accLftReg <= accLftReg + ACC_W'(termSat);
                    end else begin
                        accRghtReg <= accRghtReg + ACC_W'(termSat);
                    end
                    idxReg <= (idxReg == LAST_IDX) ? '0 : idxReg + IDX_W'(1);
                end
                VOL_L: holdLftReg <= volSat;
                VOL_R: begin
                    // Both channels publish together so the codec never sees a torn pair.
                    outLftReg  <= holdLftReg;
                    outRghtReg <= volSat;
                    outVldReg  <= 1'b1;
                end
                default: ;
            endcase

            if (bus.vld && (stateReg != IDLE)) begin
                overrunReg <= 1'b1;
            end else if (bus.clr_ovr) begin
                overrunReg <= 1'b0;
            end
        end
    end

    assign bus.aud_out_lft  = outLftReg;
    assign bus.aud_out_rght = outRghtReg;
    assign bus.out_vld      = outVldReg;
    assign bus.busy         = (stateReg != IDLE);
    assign bus.overrun      = overrunReg;

endmodule

// File: tb/tb_eq_scale_sequencer.sv
// Self-checking bench: per-cycle comparison against an arithmetic reference model plus directed literals.
module tb_eq_scale_sequencer;

    localparam int NB = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;
    int outVldCount = 0;

    eq_scale_sequencer_if #(.NUM_BANDS(NB)) ifc ();

    eq_scale_sequencer #(.NUM_BANDS(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Floor division by 2^sh, optionally after adding half of the divisor.
    function automatic int div_pow2(input longint p, input int sh);
        longint d;
        longint q;
        d = longint'(1) << sh;
`ifdef EQ_ROUND_EN
        p = p + d / 2;
`endif
        q = p / d;
        if ((p % d) != 0 && p < 0) q = q - 1;
        return int'(q);
    endfunction

    function automatic int model_channel(input logic [16*NB-1:0] bands,
                                         input logic [24*NB-1:0] pots,
                                         input logic [11:0] vol);
        int sum;
        longint a;
        longint g;
        sum = 0;
        for (int k = 0; k < NB; k++) begin
            a = longint'($signed(bands[16*k +: 16]));
            g = longint'(pots[24*k +: 24]);
            sum = sum + sat16(div_pow2(a * g, 22));
        end
        return sat16(div_pow2(longint'(sat16(sum)) * longint'(vol), 12));
    endfunction

    function automatic logic [16*NB-1:0] rep16(input logic [15:0] v);
        return {NB{v}};
    endfunction

    function automatic logic [24*NB-1:0] rep24(input logic [23:0] v);
        return {NB{v}};
    endfunction

    // Reference model: sample accepted when the previous one has finished, result due 12 edges later.
    initial begin : monitor
        int expQL[$];
        int expQR[$];
        int dueQ[$];
        int edgeCnt, freeAt, expL, expR, expVld, expOvr;
        edgeCnt = 0; freeAt = 0; expL = 0; expR = 0; expVld = 0; expOvr = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                expQL.delete(); expQR.delete(); dueQ.delete();
                edgeCnt = 0; freeAt = 0; expL = 0; expR = 0; expVld = 0; expOvr = 0;
            end else begin
                edgeCnt++;
                expVld = 0;
                if (ifc.vld && edgeCnt >= freeAt) begin
                    expQL.push_back(model_channel(ifc.band_lft, ifc.pot, ifc.vol_pot));
                    expQR.push_back(model_channel(ifc.band_rght, ifc.pot, ifc.vol_pot));
                    dueQ.push_back(edgeCnt + 12);
                    freeAt = edgeCnt + 13;
                end
                if (ifc.vld && edgeCnt < freeAt - 13 + 13 && !(dueQ.size() > 0 && freeAt == edgeCnt + 13)) begin
                    expOvr = 1;
                end else if (ifc.clr_ovr) begin
                    expOvr = 0;
                end
                if (dueQ.size() > 0 && dueQ[0] == edgeCnt) begin
                    void'(dueQ.pop_front());
                    expL = expQL.pop_front();
                    expR = expQR.pop_front();
                    expVld = 1;
                end
            end
            #1;
            if (ifc.out_vld) outVldCount++;
            chk("out_vld", int'(ifc.out_vld), expVld);
            chk("aud_out_lft", int'(ifc.aud_out_lft), expL);
            chk("aud_out_rght", int'(ifc.aud_out_rght), expR);
            chk("busy", int'(ifc.busy), int'(edgeCnt + 1 < freeAt));
            chk("overrun", int'(ifc.overrun), expOvr);
        end
    end

    task automatic pulse_vld(input logic [16*NB-1:0] bl, input logic [16*NB-1:0] br,
                             input logic [24*NB-1:0] p, input logic [11:0] v);
        @(negedge clk);
        ifc.band_lft = bl; ifc.band_rght = br; ifc.pot = p; ifc.vol_pot = v;
        ifc.vld = 1'b1;
        @(negedge clk);
        ifc.vld = 1'b0;
        // Scramble inputs: only latched operands may matter.
        ifc.band_lft = ~bl; ifc.band_rght = ~br; ifc.pot = ~p; ifc.vol_pot = ~v;
    endtask

    task automatic wait_out(output int lat, output int l, output int r);
        lat = -1; l = 0; r = 0;
        for (int k = 2; k <= 40; k++) begin
            @(negedge clk);
            if (ifc.out_vld) begin
                lat = k - 1;
                l = int'(ifc.aud_out_lft);
                r = int'(ifc.aud_out_rght);
                break;
            end
        end
    endtask

    initial begin : watchdog
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : stim
        logic [16*NB-1:0] bl, br;
        logic [24*NB-1:0] p;
        logic [11:0] v;
        int lat, l, r, cnt0;
`ifdef EQ_ROUND_EN
        int expT1L = 4999;
        int expT5L = -1;
`else
        int expT1L = 4998;
        int expT5L = -2;
`endif
        ifc.vld = 1'b0; ifc.clr_ovr = 1'b0; ifc.vol_pot = '0;
        ifc.band_lft = '0; ifc.band_rght = '0; ifc.pot = '0;

        // Pin the reference model itself with hand-computed values.
        chk("model_unity_l", model_channel(rep16(16'sd1000), rep24(24'h400000), 12'd4095), expT1L);
        chk("model_unity_r", model_channel(rep16(-16'sd1000), rep24(24'h400000), 12'd4095), -4999);
        chk("model_sat", model_channel(rep16(16'sd32767), rep24(24'h800000), 12'd4095), 32759);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Test 1: unity gain, truncation on the negative side.
        pulse_vld(rep16(16'sd1000), rep16(-16'sd1000), rep24(24'h400000), 12'd4095);
        wait_out(lat, l, r);
        chk("t1_latency", lat, 12);
        chk("t1_lft", l, expT1L);
        chk("t1_rght", r, -4999);

        // Test 2: saturating terms and sum, then zero volume.
        pulse_vld(rep16(16'sd32767), rep16(16'sd32767), rep24(24'h800000), 12'd4095);
        wait_out(lat, l, r);
        chk("t2_lft", l, 32759);
        chk("t2_rght", r, 32759);
        pulse_vld(rep16(16'sd32767), rep16(16'sd32767), rep24(24'h800000), 12'd0);
        wait_out(lat, l, r);
        chk("t2_vol0_lft", l, 0);
        chk("t2_vol0_rght", r, 0);

        // Test 3: vld while busy, with clr_ovr in the same cycle (set wins).
        cnt0 = outVldCount;
        pulse_vld(rep16(16'sd1000), rep16(-16'sd1000), rep24(24'h400000), 12'd4095);
        repeat (3) @(negedge clk);
        ifc.vld = 1'b1; ifc.clr_ovr = 1'b1;
        @(negedge clk);
        ifc.vld = 1'b0; ifc.clr_ovr = 1'b0;
        chk("t3_set_wins", int'(ifc.overrun), 1);
        repeat (25) @(negedge clk);
        chk("t3_one_out_vld", outVldCount - cnt0, 1);
        chk("t3_overrun_sticky", int'(ifc.overrun), 1);
        @(negedge clk); ifc.clr_ovr = 1'b1;
        @(negedge clk); ifc.clr_ovr = 1'b0;
        chk("t3_cleared", int'(ifc.overrun), 0);

        // Test 4: reset mid-sequence aborts without a result.
        cnt0 = outVldCount;
        pulse_vld(rep16(16'sd2000), rep16(16'sd500), rep24(24'h400000), 12'd4095);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t4_busy", int'(ifc.busy), 0);
        chk("t4_lft", int'(ifc.aud_out_lft), 0);
        chk("t4_rght", int'(ifc.aud_out_rght), 0);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("t4_no_out_vld", outVldCount - cnt0, 0);
        pulse_vld(rep16(16'sd1000), rep16(-16'sd1000), rep24(24'h400000), 12'd4095);
        wait_out(lat, l, r);
        chk("t4_after_lat", lat, 12);
        chk("t4_after_lft", l, expT1L);
        chk("t4_after_rght", r, -4999);

        // Test 5: small negative value exposes truncation vs rounding.
        bl = '0; bl[15:0] = -16'sd3;
        br = '0;
        p = '0; p[23:0] = 24'h200000;
        pulse_vld(bl, br, p, 12'd4095);
        wait_out(lat, l, r);
        chk("t5_lft", l, expT5L);
        chk("t5_rght", r, 0);

        // Test 6: back-to-back samples at minimum spacing.
        cnt0 = outVldCount;
        for (int s = 0; s < 20; s++) begin
            for (int k = 0; k < NB; k++) begin
                bl[16*k +: 16] = 16'($urandom) >>> (s % 5);
                br[16*k +: 16] = 16'($urandom) >>> ((s + k) % 7);
                p[24*k +: 24]  = 24'($urandom) >> (3 * k + (s % 4));
            end
            v = 12'($urandom);
            pulse_vld(bl, br, p, v);
            repeat (11) @(negedge clk);
        end
        repeat (14) @(negedge clk);
        chk("t6_out_vld_count", outVldCount - cnt0, 20);
        chk("t6_overrun", int'(ifc.overrun), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
